// File: rtl/mesi_emissor.sv
// Processor-side MESI controller for a small direct-mapped cache: CPU lookup, bus requests,
// victim write-back and snoop updates. Optional hit/miss counters under MESI_STATS_EN.
module mesi_emissor #(
  parameter int unsigned IDX_W = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [TAG_W+IDX_W-1:0] cpu_addr,
  output logic                   cpu_ready,
  output logic                   cpu_done,
  output logic                   bus_valid,
  output logic [1:0]             bus_msg,
  output logic [TAG_W+IDX_W-1:0] bus_addr,
  input  logic                   bus_ack,
  input  logic                   bus_shared,
  output logic                   wb,
  input  logic                   snp_valid,
  input  logic [IDX_W-1:0]       snp_index,
  input  logic [1:0]             snp_state,
`ifdef MESI_STATS_EN
  output logic [15:0]            hit_cnt,
  output logic [15:0]            miss_cnt,
`endif
  output logic [1:0]             line_state
);

  localparam int unsigned AW    = TAG_W + IDX_W;
  localparam int unsigned Lines = 2 ** IDX_W;

  localparam logic [1:0] MesiM = 2'b00;
  localparam logic [1:0] MesiE = 2'b01;
  localparam logic [1:0] MesiS = 2'b10;
  localparam logic [1:0] MesiI = 2'b11;

  localparam logic [1:0] MsgRm = 2'b01;
  localparam logic [1:0] MsgWh = 2'b10;
  localparam logic [1:0] MsgWm = 2'b11;

  typedef enum logic [2:0] {StIdle, StCheck, StWback, StBusreq, StDone} st_e;

  st_e              st_q, st_d;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [1:0]       msg_q;
  logic [AW-1:0]    bus_addr_q;
  logic [1:0]       line_q [Lines];
  logic [TAG_W-1:0] tag_q  [Lines];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       cur;
  logic             hit;
  logic [1:0]       fill_state;

  assign req_idx    = addr_q[IDX_W-1:0];
  assign req_tag    = addr_q[AW-1:IDX_W];
  assign cur        = line_q[req_idx];
  assign hit        = (cur != MesiI) && (tag_q[req_idx] == req_tag);
  assign fill_state = (msg_q == MsgRm) ? (bus_shared ? MesiS : MesiE) : MesiM;
  assign line_state = line_q[cpu_addr[IDX_W-1:0]];
  assign bus_msg    = msg_q;
  assign bus_addr   = bus_addr_q;

  always_ff @(posedge clock) begin
    if (reset) st_q <= StIdle;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle:   if (cpu_req) st_d = StCheck;
      StCheck: begin
        if (hit)              st_d = (we_q && cur == MesiS) ? StBusreq : StDone;
        else if (cur == MesiM) st_d = StWback;
        else                  st_d = StBusreq;
      end
      StWback:  if (bus_ack) st_d = StBusreq;
      StBusreq: if (bus_ack) st_d = StDone;
      StDone:   st_d = StIdle;
      default:  st_d = StIdle;
    endcase
  end

  always_comb begin
    cpu_ready = (st_q == StIdle);
    cpu_done  = (st_q == StDone);
    bus_valid = (st_q == StBusreq);
    wb        = (st_q == StWback);
  end

  // Snoop write first so a same-cycle CPU-side write to the same line overrides it.
  always_ff @(posedge clock) begin
    if (reset) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      msg_q      <= 2'b00;
      bus_addr_q <= '0;
      for (int i = 0; i < Lines; i++) begin
        line_q[i] <= MesiI;
        tag_q[i]  <= '0;
      end
    end else begin
      if (snp_valid) line_q[snp_index] <= snp_state;
      case (st_q)
        StIdle: begin
          if (cpu_req) begin
            we_q   <= cpu_we;
            addr_q <= cpu_addr;
          end
        end
        StCheck: begin
          if (hit) begin
            if (we_q && cur == MesiE) line_q[req_idx] <= MesiM;
            if (we_q && cur == MesiS) begin
              msg_q      <= MsgWh;
              bus_addr_q <= addr_q;
            end
          end else begin
            msg_q      <= we_q ? MsgWm : MsgRm;
            bus_addr_q <= (cur == MesiM) ? {tag_q[req_idx], req_idx} : addr_q;
          end
        end
        StWback: begin
          if (bus_ack) begin
            line_q[req_idx] <= MesiI;
            bus_addr_q      <= addr_q;
          end
        end
        StBusreq: begin
          if (bus_ack) begin
            line_q[req_idx] <= fill_state;
            tag_q[req_idx]  <= req_tag;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MESI_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (st_q == StCheck) begin
      if (hit && hit_cnt_q != 16'hffff)        hit_cnt_q  <= hit_cnt_q + 16'd1;
      else if (!hit && miss_cnt_q != 16'hffff) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_mesi_emissor.sv
// Directed, table-driven bench for mesi_emissor: CPU transactions with bus handshakes,
// plus hand-written snoop, collision and mid-transaction reset sequences.
module tb_mesi_emissor;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we;
  logic [5:0] cpu_addr;
  logic       cpu_ready, cpu_done, bus_valid, wb;
  logic [1:0] bus_msg;
  logic [5:0] bus_addr;
  logic       bus_ack, bus_shared;
  logic       snp_valid;
  logic [1:0] snp_index, snp_state;
  logic [1:0] line_state;
`ifdef MESI_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  mesi_emissor #(.IDX_W(2), .TAG_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_ready  (cpu_ready),
    .cpu_done   (cpu_done),
    .bus_valid  (bus_valid),
    .bus_msg    (bus_msg),
    .bus_addr   (bus_addr),
    .bus_ack    (bus_ack),
    .bus_shared (bus_shared),
    .wb         (wb),
    .snp_valid  (snp_valid),
    .snp_index  (snp_index),
    .snp_state  (snp_state),
`ifdef MESI_STATS_EN
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
`endif
    .line_state (line_state)
  );

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic       shared;
    int         wait_n;
    logic       exp_wb;
    logic [5:0] exp_wb_addr;
    logic       exp_bus;
    logic [1:0] exp_msg;
    logic [1:0] exp_state;
    int         exp_cyc;
  } vec_t;

  typedef struct {
    logic       saw_wb;
    logic [5:0] wb_addr;
    logic       saw_bus;
    logic [1:0] msg;
    logic [5:0] baddr;
    int         cyc;
    logic       done;
    logic [1:0] state;
    logic       done_after;
    logic       ready_after;
  } res_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request and service the bus until cpu_done or a 40-cycle bound.
  task automatic run_req(input vec_t v, output res_t r);
    int waited;
    waited = 0;
    r = '{saw_wb: 1'b0, wb_addr: '0, saw_bus: 1'b0, msg: '0, baddr: '0, cyc: 0,
          done: 1'b0, state: '0, done_after: 1'b0, ready_after: 1'b0};
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr;
    @(negedge clock);
    cpu_req = 1'b0;
    r.cyc = 1;
    while (!cpu_done && r.cyc < 40) begin
      if (wb) begin
        r.saw_wb  = 1'b1;
        r.wb_addr = bus_addr;
        bus_ack   = 1'b1;
      end else if (bus_valid) begin
        r.saw_bus = 1'b1;
        r.msg     = bus_msg;
        r.baddr   = bus_addr;
        if (waited >= v.wait_n) begin
          bus_ack    = 1'b1;
          bus_shared = v.shared;
        end else begin
          waited++;
        end
      end
      @(negedge clock);
      bus_ack = 1'b0; bus_shared = 1'b0;
      r.cyc++;
    end
    r.done  = cpu_done;
    r.state = line_state;
    @(negedge clock);
    r.done_after  = cpu_done;
    r.ready_after = cpu_ready;
  endtask

  task automatic check_vec(input string tag, input vec_t v, input res_t r);
    chk({tag, "_done"}, 32'(r.done), 32'd1);
    chk({tag, "_cyc"}, r.cyc, v.exp_cyc);
    chk({tag, "_wb"}, 32'(r.saw_wb), 32'(v.exp_wb));
    if (v.exp_wb) chk({tag, "_wb_addr"}, 32'(r.wb_addr), 32'(v.exp_wb_addr));
    chk({tag, "_bus"}, 32'(r.saw_bus), 32'(v.exp_bus));
    if (v.exp_bus) begin
      chk({tag, "_msg"}, 32'(r.msg), 32'(v.exp_msg));
      chk({tag, "_baddr"}, 32'(r.baddr), 32'(v.addr));
    end
    chk({tag, "_state"}, 32'(r.state), 32'(v.exp_state));
    chk({tag, "_done_pulse"}, 32'(r.done_after), 32'd0);
    chk({tag, "_ready"}, 32'(r.ready_after), 32'd1);
  endtask

  initial begin
    res_t r;
    vec_t v;
    int   bound;

    //            we    addr   sh  wt  wb   wbaddr bus  msg    state  cyc
    vecs[0] = '{1'b0, 6'h05, 1'b0, 0, 1'b0, 6'h00, 1'b1, 2'b01, 2'b01, 3};
    vecs[1] = '{1'b1, 6'h05, 1'b0, 0, 1'b0, 6'h00, 1'b0, 2'b00, 2'b00, 2};
    vecs[2] = '{1'b0, 6'h05, 1'b0, 0, 1'b0, 6'h00, 1'b0, 2'b00, 2'b00, 2};
    vecs[3] = '{1'b0, 6'h06, 1'b1, 0, 1'b0, 6'h00, 1'b1, 2'b01, 2'b10, 3};
    vecs[4] = '{1'b1, 6'h06, 1'b0, 2, 1'b0, 6'h00, 1'b1, 2'b10, 2'b00, 5};
    vecs[5] = '{1'b0, 6'h09, 1'b1, 0, 1'b1, 6'h05, 1'b1, 2'b01, 2'b10, 4};
    vecs[6] = '{1'b0, 6'h09, 1'b0, 0, 1'b0, 6'h00, 1'b0, 2'b00, 2'b10, 2};
    vecs[7] = '{1'b1, 6'h0d, 1'b0, 0, 1'b0, 6'h00, 1'b1, 2'b11, 2'b00, 3};
    vecs[8] = '{1'b1, 6'h03, 1'b0, 0, 1'b0, 6'h00, 1'b1, 2'b11, 2'b00, 3};
    vecs[9] = '{1'b0, 6'h3f, 1'b0, 0, 1'b1, 6'h03, 1'b1, 2'b01, 2'b01, 4};

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 6'h00;
    bus_ack = 1'b0; bus_shared = 1'b0;
    snp_valid = 1'b0; snp_index = 2'd0; snp_state = 2'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    chk("rst_ready", 32'(cpu_ready), 32'd1);
    chk("rst_done", 32'(cpu_done), 32'd0);
    chk("rst_valid", 32'(bus_valid), 32'd0);
    chk("rst_wb", 32'(wb), 32'd0);
    chk("rst_msg", 32'(bus_msg), 32'd0);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_line", 32'(line_state), 32'h3);

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i], r);
      check_vec($sformatf("v%0d", i), vecs[i], r);
    end

    // Snoop invalidates idx 1 while idle; the next read of 0x0d must miss.
    @(negedge clock);
    snp_valid = 1'b1; snp_index = 2'd1; snp_state = 2'b11;
    @(negedge clock);
    snp_valid = 1'b0;
    cpu_addr = 6'h0d;
    #1 chk("snp_idle_line", 32'(line_state), 32'h3);
    v = '{1'b0, 6'h0d, 1'b0, 0, 1'b0, 6'h00, 1'b1, 2'b01, 2'b01, 3};
    run_req(v, r);
    check_vec("snp_rm", v, r);

    // Write hit on E with a same-cycle snoop to the same line: CPU write wins.
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h0d;
    @(negedge clock);
    cpu_req = 1'b0;
    snp_valid = 1'b1; snp_index = 2'd1; snp_state = 2'b10;
    @(negedge clock);
    snp_valid = 1'b0;
    chk("coll_done", 32'(cpu_done), 32'd1);
    chk("coll_valid", 32'(bus_valid), 32'd0);
    chk("coll_line", 32'(line_state), 32'h0);
    @(negedge clock);

    // Miss on idx 0, snoop during BUSREQ, then reset while awaiting ack.
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h10;
    @(negedge clock);
    cpu_req = 1'b0;
    bound = 0;
    while (!bus_valid && bound < 20) begin
      @(negedge clock);
      bound++;
    end
    chk("mid_valid_seen", 32'(bus_valid), 32'd1);
    chk("mid_msg", 32'(bus_msg), 32'h1);
    snp_valid = 1'b1; snp_index = 2'd0; snp_state = 2'b10;
    @(negedge clock);
    snp_valid = 1'b0;
    chk("mid_snp_keep_valid", 32'(bus_valid), 32'd1);
    chk("mid_snp_line", 32'(line_state), 32'h2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_valid", 32'(bus_valid), 32'd0);
    chk("mid_rst_ready", 32'(cpu_ready), 32'd1);
    chk("mid_rst_msg", 32'(bus_msg), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 6'(i);
      #1 chk($sformatf("mid_rst_line%0d", i), 32'(line_state), 32'h3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mesi_emissor.md
Name: mesi_emissor

Overview:
- Processor-side MESI controller for a small direct-mapped cache.
- Accepts CPU read/write requests, looks up the line state/tag, updates MESI state, and issues bus messages (rh/rm/wh/wm) with a valid/ack handshake.
- Performs victim write-back when a miss evicts an M line.
- Accepts snoop state updates from the bus-side receptor, which is the other end of the same bus message protocol.

Parameters:
- IDX_W, 2, index width; number of lines = 2**IDX_W.
- TAG_W, 4, tag width; cpu_addr width = TAG_W+IDX_W.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  request strobe, sampled only when cpu_ready=1
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  TAG_W+IDX_W  {tag,index}
- cpu_ready  out  1  controller idle, can accept a request
- cpu_done  out  1  one-cycle pulse, request complete
- bus_valid  out  1  bus message valid; held until bus_ack
- bus_msg  out  2  00 rh, 01 rm, 10 wh, 11 wm
- bus_addr  out  TAG_W+IDX_W  address of message or write-back
- bus_ack  in  1  bus accepted current message/write-back
- bus_shared  in  1  another cache holds the line; sampled with bus_ack on rm
- wb  out  1  victim write-back request; held until bus_ack
- snp_valid  in  1  snoop state update
- snp_index  in  IDX_W  line to update
- snp_state  in  2  new state (00 M, 01 E, 10 S, 11 I)
- line_state  out  2  state of the line at cpu_addr index (combinational read, debug)

Behaviour:
- Reset:
  - All lines set to I, tags set to 0.
  - FSM set to IDLE.
  - cpu_ready=1; cpu_done, bus_valid, wb = 0; bus_msg=00; bus_addr=0.
  - Reset mid-operation aborts any in-flight transaction with no state write.
- FSM states: IDLE, CHECK, WBACK, BUSREQ, DONE.
- IDLE: if cpu_req, latch we/addr, go to CHECK; cpu_ready=0 from the next cycle.
- CHECK:
  - Hit = line state != I and tag match.
  - Read hit (M/E/S) -> DONE, state unchanged, no bus traffic.
  - Write hit M -> DONE.
  - Write hit E -> state M, DONE, no message.
  - Write hit S -> BUSREQ with msg wh.
  - Miss, victim M -> WBACK.
  - Other miss -> BUSREQ with msg rm (read) or wm (write).
- WBACK:
  - wb=1, bus_addr={victim tag,index} until bus_ack.
  - On ack: wb=0, victim line set to I, go to BUSREQ.
- BUSREQ:
  - bus_valid=1, stable msg/addr until bus_ack.
  - On ack, write line state and tag:
    - wh -> M.
    - wm -> M.
    - rm -> S if bus_shared else E.
  - bus_valid deasserts in the cycle after ack; then go to DONE.
- DONE: cpu_done=1 for one cycle, then IDLE; cpu_ready=1.
- Latency: hit completes with cpu_done 2 cycles after the accept edge. A miss adds 1 cycle per handshake plus bus wait cycles.
- Snoop: snp_valid writes snp_state to line snp_index in any FSM state.
- Snoop/CPU write collision: if the snoop and a CPU-side state write target the same index in the same cycle, the CPU-side write wins.
- A snoop arriving while BUSREQ/WBACK is pending does not cancel the transaction.
- Only 2-bit encodings are defined. No illegal states exist, so no special handling is required.

Optional Feature:
- MESI_STATS_EN
  - Defined: adds outputs hit_cnt[15:0] and miss_cnt[15:0].
    - Each increments once per request at CHECK.
    - Both saturate at FFFF and clear on reset.
  - Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- After reset, read 0x05 (tag 1, idx 1), ack with shared=0 -> bus_msg=01, line_state=01 (E), cpu_done pulse.
- Write 0x05 after previous test -> no bus_valid, line_state=00 (M), cpu_done 2 cycles after accept.
- Line idx 2 in S; write 0x06 -> bus_msg=10 (wh), after ack line_state=00.
- Line idx 1 in M tag 1; read 0x09 (tag 2) -> wb=1 with bus_addr=0x05; after ack, bus_msg=01 bus_addr=0x09; shared=1 -> line_state=10 (S).
- Snoop snp_index=1, snp_state=11 while in IDLE -> line_state=11; next read 0x05 misses and emits rm.
- Assert reset while bus_valid=1 awaiting ack -> next cycle bus_valid=0, cpu_ready=1, all lines 11.
